mig_truth_table_eval: RTL and testbench

//  Programmable majority-inverter-graph (MIG) evaluator for the function-classification flow.

---
 rtl/mig_pkg.sv | 50 +++++
 rtl/mig_truth_table_eval_if.sv | 29 ++
 rtl/mig_net_comb.sv | 27 ++
 rtl/mig_truth_table_eval.sv | 181 ++++++++++++++++++
 tb/tb_mig_truth_table_eval.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/mig_pkg.sv
// Shared types, constants and helpers for the MIG truth-table evaluator.
package mig_pkg;

  localparam int NUM_IN     = 7;
  localparam int NUM_GATES  = 8;
  localparam int WORD_W     = 32;
  localparam int NUM_CODES  = 1 + NUM_IN + NUM_GATES;
  localparam int SEL_W      = $clog2(NUM_CODES);
  localparam int IDX_W      = $clog2(NUM_GATES);
  localparam int OP_W       = SEL_W + 1;
  localparam int PROG_W     = 3 * OP_W;
  localparam int WORD_IDX_W = $clog2(WORD_W);

  // Operand code map: 0 = const0, 1..NUM_IN = inputs, then gates.
  localparam logic [SEL_W-1:0] SEL_CONST0    = SEL_W'(32'd0);
  localparam logic [SEL_W-1:0] SEL_IN_BASE   = SEL_W'(32'd1);
  localparam logic [SEL_W-1:0] SEL_GATE_BASE = SEL_W'(NUM_IN + 1);

  typedef struct packed {
    logic             inv;
    logic [SEL_W-1:0] sel;
  } mig_operand_t;

  // Field order puts c in the MSBs so prog_op {c,b,a} casts directly.
  typedef struct packed {
    mig_operand_t c;
    mig_operand_t b;
    mig_operand_t a;
  } mig_gate_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } mig_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic operand_value(input logic [NUM_CODES-1:0] codes,
                                         input mig_operand_t op);
    return codes[op.sel] ^ op.inv;
  endfunction

  function automatic logic sel_in_range(input logic [SEL_W-1:0] sel, input int max_code);
    return (int'(sel) <= max_code);
  endfunction

endpackage

// File: rtl/mig_truth_table_eval_if.sv
// Programming, control and truth-table stream bundle for the MIG evaluator.
interface mig_truth_table_eval_if;
  import mig_pkg::*;

  logic              prog_we;
  logic [IDX_W-1:0]  prog_idx;
  logic [PROG_W-1:0] prog_op;
  logic [SEL_W-1:0]  out_sel;
  logic              out_inv;
  logic              start;
  logic              busy;
  logic              tt_valid;
  logic              tt_ready;
  logic [WORD_W-1:0] tt_word;
  logic              tt_last;
  logic              done;
  logic              err;

  modport master (
    output prog_we, prog_idx, prog_op, out_sel, out_inv, start, tt_ready,
    input  busy, tt_valid, tt_word, tt_last, done, err
  );

  modport slave (
    input  prog_we, prog_idx, prog_op, out_sel, out_inv, start, tt_ready,
    output busy, tt_valid, tt_word, tt_last, done, err
  );

endinterface

// File: rtl/mig_net_comb.sv
// Combinational evaluation of the whole MAJ3 network for one minterm.
module mig_net_comb
  import mig_pkg::*;
(
  input  mig_gate_t [NUM_GATES-1:0] prog,
  input  logic [NUM_IN-1:0]         minterm,
  output logic [NUM_GATES-1:0]      gate_val
);

  logic [NUM_CODES-1:0] avail_s;

  // Gates are evaluated in slot order; codes of later gates still read 0 when
  // an earlier gate is evaluated, so the netlist is loop-free by construction.
  always_comb begin
    avail_s                       = '0;
    avail_s[SEL_CONST0]           = 1'b0;
    avail_s[SEL_IN_BASE +: NUM_IN] = minterm;
    gate_val                      = '0;
    for (int k = 0; k < NUM_GATES; k++) begin
      gate_val[k] = maj3(operand_value(avail_s, prog[k].a),
                         operand_value(avail_s, prog[k].b),
                         operand_value(avail_s, prog[k].c));
      avail_s[int'(SEL_GATE_BASE) + k] = gate_val[k];
    end
  end

endmodule

// File: rtl/mig_truth_table_eval.sv
// MIG truth-table evaluator: program store, minterm sweep FSM, word packer
// and a single-entry valid/ready output register.
module mig_truth_table_eval
  import mig_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  mig_truth_table_eval_if.slave bus
);

  mig_gate_t [NUM_GATES-1:0] prog_q, prog_d;
  mig_state_t                state_q, state_d;
  logic [NUM_IN-1:0]         m_q, m_d;
  logic [WORD_W-1:0]         shreg_q, shreg_d;
  logic [WORD_W-1:0]         word_q, word_d;
  logic [SEL_W-1:0]          out_sel_q, out_sel_d;
  logic                      out_inv_q, out_inv_d;
  logic                      valid_q, valid_d;
  logic                      last_q, last_d;
  logic                      done_q, done_d;
  logic                      busy_q, busy_d;
  logic                      err_q, err_d;

  mig_gate_t                 wr_gate_s;
  logic                      wr_legal_s;
  logic                      prog_err_s;
  logic [NUM_GATES-1:0]      gate_val_s;
  logic [NUM_CODES-1:0]      codes_s;
  logic                      f_s;
  logic                      accept_s;
  logic                      stall_s;

  mig_net_comb u_net (
    .prog     (prog_q),
    .minterm  (m_q),
    .gate_val (gate_val_s)
  );

  // Selected network output for the current minterm.
  always_comb begin
    codes_s = {gate_val_s, m_q, 1'b0};
    f_s     = codes_s[out_sel_q] ^ out_inv_q;
  end

  // Program writes: legal only from IDLE and only to lower-numbered operands.
  always_comb begin
    wr_gate_s  = mig_gate_t'(bus.prog_op);
    wr_legal_s = sel_in_range(wr_gate_s.a.sel, NUM_IN + int'(bus.prog_idx)) &&
                 sel_in_range(wr_gate_s.b.sel, NUM_IN + int'(bus.prog_idx)) &&
                 sel_in_range(wr_gate_s.c.sel, NUM_IN + int'(bus.prog_idx));
    prog_d     = prog_q;
    prog_err_s = 1'b0;
    if (bus.prog_we) begin
      if (busy_q || !wr_legal_s) begin
        prog_err_s = 1'b1;
      end else begin
        prog_d[bus.prog_idx] = wr_gate_s;
      end
    end else begin
      prog_err_s = 1'b0;
    end
  end

  // Sweep FSM next-state, minterm counter, word packing and output handshake.
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    shreg_d   = shreg_q;
    word_d    = word_q;
    out_sel_d = out_sel_q;
    out_inv_d = out_inv_q;
    valid_d   = valid_q;
    last_d    = last_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    err_d     = err_q | prog_err_s;
    accept_s  = valid_q && bus.tt_ready;
    stall_s   = valid_q && !bus.tt_ready;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (sel_in_range(bus.out_sel, NUM_CODES - 1)) begin
            state_d   = ST_RUN;
            busy_d    = 1'b1;
            m_d       = '0;
            shreg_d   = '0;
            out_sel_d = bus.out_sel;
            out_inv_d = bus.out_inv;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (accept_s) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
        end else begin
          valid_d = valid_q;
        end
        if (!stall_s) begin
          shreg_d[m_q[WORD_IDX_W-1:0]] = f_s;
          m_d = m_q + NUM_IN'(32'd1);
          // Word complete: hand it to the output register (no bubble on accept).
          if (&m_q[WORD_IDX_W-1:0]) begin
            word_d  = shreg_d;
            valid_d = 1'b1;
            last_d  = &m_q;
            if (&m_q) begin
              state_d = ST_DRAIN;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (accept_s) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  // State registers; reset also clears the program store.
  always_ff @(posedge clk) begin
    if (rst) begin
      prog_q    <= '0;
      state_q   <= ST_IDLE;
      m_q       <= '0;
      shreg_q   <= '0;
      word_q    <= '0;
      out_sel_q <= '0;
      out_inv_q <= 1'b0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      prog_q    <= prog_d;
      state_q   <= state_d;
      m_q       <= m_d;
      shreg_q   <= shreg_d;
      word_q    <= word_d;
      out_sel_q <= out_sel_d;
      out_inv_q <= out_inv_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.tt_valid = valid_q;
  assign bus.tt_word  = word_q;
  assign bus.tt_last  = last_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_mig_truth_table_eval.sv
// Directed, table-driven bench for the MIG truth-table evaluator.
module tb_mig_truth_table_eval;
  import mig_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mig_truth_table_eval_if bus();

  mig_truth_table_eval dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // One sweep scenario: gate 0/1 programs, output select and the 4 expected
  // words packed {w3,w2,w1,w0}.
  typedef struct packed {
    logic [14:0]  g0;
    logic [14:0]  g1;
    logic [3:0]   sel;
    logic         inv;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [7];

  localparam logic [14:0] OP_MAJ012 = {5'h03, 5'h02, 5'h01};
  localparam logic [14:0] OP_AND01  = {5'h00, 5'h02, 5'h01};
  localparam logic [14:0] OP_NAND   = {5'h00, 5'h10, 5'h18};
  localparam logic [14:0] OP_ZERO   = 15'h0000;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic write_gate(input logic [2:0] idx, input logic [14:0] op);
    bus.prog_idx = idx;
    bus.prog_op  = op;
    bus.prog_we  = 1'b1;
    step();
    bus.prog_we  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // intrude: 0 none, 1 start pulse while busy, 2 prog_we while busy (at cycle 10)
  task automatic run_sweep(input string name, input logic [3:0] sel, input logic inv,
                           input logic [127:0] exp, input int stall_len,
                           input int intrude, input int exp_done);
    logic [31:0] got [4];
    logic [3:0]  lastv;
    logic [31:0] held;
    logic        stable;
    int          nw;
    int          first_valid;
    int          done_at;
    nw = 0; first_valid = -1; done_at = -1; stable = 1'b1; lastv = 4'b0000; held = 32'h0;
    for (int i = 0; i < 4; i++) got[i] = 32'h0;
    bus.out_sel  = sel;
    bus.out_inv  = inv;
    bus.tt_ready = 1'b1;
    bus.start    = 1'b1;
    step();
    bus.start = 1'b0;
    check({name, "_busy"}, 32'(bus.busy), 32'd1);
    for (int n = 1; n <= 400 && done_at < 0; n++) begin
      step();
      bus.start   = 1'b0;
      bus.prog_we = 1'b0;
      if (bus.done) done_at = n;
      if (bus.tt_valid) begin
        if (first_valid < 0) begin
          first_valid = n;
          held = bus.tt_word;
        end
        if (nw == 0 && bus.tt_word !== held) stable = 1'b0;
        if (stall_len > 0 && nw == 0 && (n - first_valid) < stall_len) begin
          bus.tt_ready = 1'b0;
        end else begin
          bus.tt_ready = 1'b1;
          if (nw < 4) begin
            got[nw]   = bus.tt_word;
            lastv[nw] = bus.tt_last;
          end
          nw++;
        end
      end else begin
        if (first_valid >= 0 && nw == 0) stable = 1'b0;
        bus.tt_ready = 1'b1;
      end
      if (n == 10 && intrude == 1) begin
        bus.start   = 1'b1;
        bus.out_sel = 4'd0;
        bus.out_inv = 1'b1;
      end
      if (n == 10 && intrude == 2) begin
        bus.prog_we  = 1'b1;
        bus.prog_idx = 3'd0;
        bus.prog_op  = OP_ZERO;
      end
    end
    check({name, "_nwords"}, 32'(nw), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("%s_word%0d", name, i), got[i], exp[32*i +: 32]);
    check({name, "_last"}, 32'(lastv), 32'h8);
    check({name, "_first_valid"}, 32'(first_valid), 32'd32);
    check({name, "_done_cycle"}, 32'(done_at), 32'(exp_done));
    check({name, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    if (stall_len > 0) check({name, "_stall_stable"}, 32'(stable), 32'd1);
    step();
    check({name, "_done_pulse"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    bus.prog_we = 1'b0; bus.prog_idx = 3'd0; bus.prog_op = OP_ZERO;
    bus.out_sel = 4'd0; bus.out_inv = 1'b0; bus.start = 1'b0; bus.tt_ready = 1'b1;

    vecs[0] = '{g0: OP_MAJ012, g1: OP_ZERO, sel: 4'd8,  inv: 1'b0, exp: {4{32'hE8E8E8E8}}};
    vecs[1] = '{g0: OP_MAJ012, g1: OP_ZERO, sel: 4'd0,  inv: 1'b1, exp: {4{32'hFFFFFFFF}}};
    vecs[2] = '{g0: OP_MAJ012, g1: OP_ZERO, sel: 4'd7,  inv: 1'b0,
                exp: {32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000000}};
    vecs[3] = '{g0: OP_MAJ012, g1: OP_ZERO, sel: 4'd1,  inv: 1'b0, exp: {4{32'hAAAAAAAA}}};
    vecs[4] = '{g0: OP_MAJ012, g1: OP_ZERO, sel: 4'd8,  inv: 1'b1, exp: {4{32'h17171717}}};
    vecs[5] = '{g0: OP_AND01,  g1: OP_NAND, sel: 4'd9,  inv: 1'b0, exp: {4{32'h77777777}}};
    vecs[6] = '{g0: OP_AND01,  g1: OP_NAND, sel: 4'd10, inv: 1'b0, exp: {4{32'h00000000}}};

    step();
    step();
    rst = 1'b0;
    check("rst_busy",  32'(bus.busy),     32'd0);
    check("rst_valid", 32'(bus.tt_valid), 32'd0);
    check("rst_last",  32'(bus.tt_last),  32'd0);
    check("rst_done",  32'(bus.done),     32'd0);
    check("rst_err",   32'(bus.err),      32'd0);
    check("rst_word",  bus.tt_word,       32'h0);

    for (int i = 0; i < 7; i++) begin
      write_gate(3'd0, vecs[i].g0);
      write_gate(3'd1, vecs[i].g1);
      run_sweep($sformatf("vec%0d", i), vecs[i].sel, vecs[i].inv, vecs[i].exp, 0, 0, 129);
    end
    check("err_after_table", 32'(bus.err), 32'd0);

    // Back-pressure on the first word for 40 cycles.
    write_gate(3'd0, OP_MAJ012);
    write_gate(3'd1, OP_ZERO);
    run_sweep("stall40", 4'd8, 1'b0, {4{32'hE8E8E8E8}}, 40, 0, 169);

    // start while busy is ignored without error.
    run_sweep("start_busy", 4'd8, 1'b0, {4{32'hE8E8E8E8}}, 0, 1, 129);
    check("start_busy_err", 32'(bus.err), 32'd0);

    // Illegal forward/self references are dropped and flag err.
    write_gate(3'd0, OP_AND01);
    write_gate(3'd1, OP_NAND);
    check("legal_err", 32'(bus.err), 32'd0);
    write_gate(3'd1, {5'h00, 5'h00, 5'h09});
    check("self_ref_err", 32'(bus.err), 32'd1);
    write_gate(3'd1, {5'h00, 5'h00, 5'h0D});
    write_gate(3'd0, {5'h08, 5'h00, 5'h00});
    run_sweep("dropped", 4'd9, 1'b0, {4{32'h77777777}}, 0, 0, 129);
    check("err_sticky", 32'(bus.err), 32'd1);

    // Only reset clears err; prog_we while busy is ignored and flags err.
    do_reset();
    check("err_cleared", 32'(bus.err), 32'd0);
    write_gate(3'd0, OP_MAJ012);
    run_sweep("we_busy", 4'd8, 1'b0, {4{32'hE8E8E8E8}}, 0, 2, 129);
    check("we_busy_err", 32'(bus.err), 32'd1);

    // Reset in the middle of word 2 aborts the sweep.
    do_reset();
    write_gate(3'd0, OP_MAJ012);
    bus.out_sel = 4'd8; bus.out_inv = 1'b0; bus.tt_ready = 1'b1; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int n = 1; n <= 70; n++) step();
    check("mid_busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_busy",  32'(bus.busy),     32'd0);
    check("mid_rst_valid", 32'(bus.tt_valid), 32'd0);
    check("mid_rst_done",  32'(bus.done),     32'd0);
    seen = 0;
    for (int n = 0; n < 200; n++) begin
      step();
      if (bus.done || bus.tt_valid || bus.busy) seen++;
    end
    check("mid_rst_quiet", 32'(seen), 32'd0);
    run_sweep("prog_cleared", 4'd8, 1'b0, {4{32'h00000000}}, 0, 0, 129);
    write_gate(3'd0, OP_MAJ012);
    run_sweep("restart", 4'd8, 1'b0, {4{32'hE8E8E8E8}}, 0, 0, 129);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
